// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the
// RV32I data-memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic illegal_f3(input logic we, input logic [2:0] funct3);
        if (we)
            illegal_f3 = (funct3 > F3_W);
        else
            illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_byte_ram #(
    parameter int unsigned DEPTH = 128,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i])
                mem[addr][i] <= wdata[8*i +: 8];
        end
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I load/store data-memory controller: one request at a time, optional
// wait states, byte-lane steering and load sign/zero extension.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_fault
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("dmem_ctrl: WAIT_STATES must be 0..15");
    end

    localparam int unsigned DEPTH    = 2 ** (DM_ADDRESS - 2);
    localparam bit          NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]  CNT_LAST = 4'(NO_WAIT ? 0 : WAIT_STATES - 1);

    dmem_state_t state, state_d;
    logic [3:0]            cnt;
    logic                  accept, go;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  fault_q, rd_en_q;
    logic [2:0]            rd_f3_q;
    logic [1:0]            rd_lane_q;

    logic                  acc_we, acc_bad, ram_re;
    logic [2:0]            acc_f3;
    logic [DM_ADDRESS-1:0] acc_addr;
    logic [31:0]           acc_wdata, ram_wdata, ram_rdata;
    logic [3:0]            be, ram_be;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_fault = fault_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state;
        go      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = NO_WAIT ? RESP : WAIT;
                    go      = NO_WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_d = RESP;
                    go      = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the RAM is hit on the accept edge itself, so the
    // access fields come straight from the request instead of the latches.
    assign acc_we    = (state == IDLE) ? req_we     : we_q;
    assign acc_f3    = (state == IDLE) ? req_funct3 : f3_q;
    assign acc_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata  : wdata_q;
    assign acc_bad   = misaligned(acc_f3, acc_addr[1:0]) || illegal_f3(acc_we, acc_f3);

    always_comb begin
        be        = '0;
        ram_wdata = acc_wdata;
        case (acc_f3[1:0])
            2'b00: begin
                be        = 4'b0001 << acc_addr[1:0];
                ram_wdata = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{acc_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = '0;
        endcase
    end

    assign ram_be = (go && acc_we && !acc_bad) ? be : '0;
    assign ram_re = go && !acc_we && !acc_bad;

    dmem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (acc_addr[DM_ADDRESS-1:2]),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_f3_q   <= '0;
            rd_lane_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (go) begin
                fault_q   <= acc_bad;
                rd_en_q   <= ram_re;
                rd_f3_q   <= acc_f3;
                rd_lane_q <= acc_addr[1:0];
            end
        end
    end

    // Extension works on the registered RAM word using the fields captured
    // alongside the read, so the result stays stable until the next access.
    always_comb begin
        resp_rdata = '0;
        if (rd_en_q) begin
            case (rd_f3_q)
                F3_B:    resp_rdata = {{24{ram_rdata[8*rd_lane_q + 7]}}, ram_rdata[8*rd_lane_q +: 8]};
                F3_BU:   resp_rdata = {24'b0, ram_rdata[8*rd_lane_q +: 8]};
                F3_H:    resp_rdata = rd_lane_q[1] ? {{16{ram_rdata[31]}}, ram_rdata[31:16]}
                                                   : {{16{ram_rdata[15]}}, ram_rdata[15:0]};
                F3_HU:   resp_rdata = rd_lane_q[1] ? {16'b0, ram_rdata[31:16]}
                                                   : {16'b0, ram_rdata[15:0]};
                F3_W:    resp_rdata = ram_rdata;
                default: resp_rdata = '0;
            endcase
        end
    end

endmodule
